// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
//
// Shares one async_fifo write port among NUM_REQ valid/ready requesters that
// live in the write clock domain. Arbitration is round-robin and grants are
// burst-locked: the granted requester keeps the port until it presents an
// accepted beat with tlast, or until BURST_LEN beats have been accepted.
// Every grant costs one idle (IDLE state) cycle. The output stage is a single
// register slice, so each accepted beat appears on fifo_write_* one cycle
// later, tagged with its source index on out_tid.
//
// Handshake rule (all valid/ready pairs on this block): a beat transfers on a
// rising clk edge where valid and ready are both 1. A source holding valid=1
// with ready=0 keeps its data stable; this block does so on fifo_write_*.
//
// Ports
//   clk               in   clock, all logic on posedge
//   reset_n           in   synchronous active-low reset
//   req_tvalid        in   [NUM_REQ]            per-requester valid
//   req_tready        out  [NUM_REQ]            per-requester ready (one-hot or zero)
//   req_tlast         in   [NUM_REQ]            per-requester end-of-burst marker
//   req_tdata         in   [NUM_REQ*DATA_WIDTH] requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_write_tvalid out  output beat valid
//   fifo_write_tready in   output beat ready
//   fifo_write_data   out  [DATA_WIDTH]         output beat data
//   out_tid           out  [ID_WIDTH]           source index of the output beat
//   grant_id          out  [ID_WIDTH]           granted requester (meaningful while busy)
//   busy              out  1 while the FSM is in BURST (doubles as the FSM state view)
// ---------------------------------------------------------------------------
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 128,
    parameter int BURST_LEN  = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_tvalid,
    output logic [NUM_REQ-1:0]            req_tready,
    input  logic [NUM_REQ-1:0]            req_tlast,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_tdata,
    output logic                          fifo_write_tvalid,
    input  logic                          fifo_write_tready,
    output logic [DATA_WIDTH-1:0]         fifo_write_data,
    output logic [ID_WIDTH-1:0]           out_tid,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          busy
);

    localparam int                CNT_W    = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(BURST_LEN - 1);
    localparam logic [ID_WIDTH-1:0] LAST_RST = ID_WIDTH'(NUM_REQ - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    beat_cnt;
    logic [ID_WIDTH-1:0] last_grant;

    // Round-robin pick: first requesting index after last_grant, wrapping.
    logic                arb_found;
    logic [ID_WIDTH-1:0] arb_idx;

    always_comb begin
        int idx;
        arb_found = 1'b0;
        arb_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!arb_found && req_tvalid[ID_WIDTH'(idx)]) begin
                arb_found = 1'b1;
                arb_idx   = ID_WIDTH'(idx);
            end
        end
    end

    // Signals of the currently granted requester.
    logic                  g_valid;
    logic                  g_last;
    logic [DATA_WIDTH-1:0] g_data;

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_WIDTH'(i)) begin
                g_valid = req_tvalid[i];
                g_last  = req_tlast[i];
                g_data  = req_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Output slice can take a beat when empty or when its beat leaves now.
    logic out_ready;
    logic in_burst;
    logic accept;

    assign out_ready = !fifo_write_tvalid || fifo_write_tready;
    assign in_burst  = reset_n && (state == S_BURST);
    assign accept    = in_burst && g_valid && out_ready;
    assign busy      = (state == S_BURST);

    // Only the granted requester ever sees ready; held low during reset.
    always_comb begin
        req_tready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (in_burst && (grant_id == ID_WIDTH'(i))) begin
                req_tready[i] = out_ready;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= S_IDLE;
            beat_cnt          <= '0;
            last_grant        <= LAST_RST;
            grant_id          <= '0;
            fifo_write_tvalid <= 1'b0;
            fifo_write_data   <= '0;
            out_tid           <= '0;
        end else begin
            // Output register: load wins over drain in the same cycle.
            if (accept) begin
                fifo_write_tvalid <= 1'b1;
                fifo_write_data   <= g_data;
                out_tid           <= grant_id;
            end else if (fifo_write_tready) begin
                fifo_write_tvalid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (arb_found) begin
                        grant_id <= arb_idx;
                        beat_cnt <= '0;
                        state    <= S_BURST;
                    end
                end
                S_BURST: begin
                    // A stalled granted requester keeps the grant indefinitely.
                    if (accept) begin
                        if (g_last || (beat_cnt == CNT_MAX)) begin
                            last_grant <= grant_id;
                            beat_cnt   <= '0;
                            state      <= S_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
